// File: rtl/sram_bus_arbiter_pkg.sv
// Shared definitions for the sram-like bus arbiter: requester ids,
// FIFO sizing limits and the request lock states.
package sram_bus_arbiter_pkg;

  // Requester ids, also stored as FIFO entries
  localparam logic SRC_INST = 1'b0;
  localparam logic SRC_DATA = 1'b1;

  // Largest supported number of outstanding transactions and derived widths
  localparam int MAX_DEPTH = 4;
  localparam int PTR_W     = 2;
  localparam int CNT_W     = 3;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LOCK_INST = 2'd1,
    LOCK_DATA = 2'd2
  } lock_state_t;

  // Advance a FIFO pointer, wrapping at the configured depth
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr, input int depth);
    logic [PTR_W-1:0] res;
    if (int'(ptr) == depth - 1) res = '0;
    else                        res = ptr + PTR_W'(1);
    return res;
  endfunction

endpackage

// File: rtl/sram_bus_arbiter_owner_fifo.sv
// Small FIFO of 1-bit owner ids, one entry per accepted-but-unanswered
// bus transaction. Head is read combinationally so a response can be
// routed in the same cycle it arrives.
module sram_bus_arbiter_owner_fifo
  import sram_bus_arbiter_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             push_id,
  input  logic             pop,
  output logic             head_id,
  output logic [CNT_W-1:0] count,
  output logic             empty,
  output logic             full
);

  logic [PTR_W-1:0]     wr_ptr_reg, wr_ptr_next;
  logic [PTR_W-1:0]     rd_ptr_reg, rd_ptr_next;
  logic [CNT_W-1:0]     count_reg, count_next;
  logic [MAX_DEPTH-1:0] mem_reg;
  logic [MAX_DEPTH-1:0] wr_en;

  // Per-entry write enables; entries beyond DEPTH are never written
  generate
    for (genvar gi = 0; gi < MAX_DEPTH; gi++) begin : g_wr_en
      if (gi < DEPTH) begin : g_used
        assign wr_en[gi] = push && (wr_ptr_reg == PTR_W'(gi));
      end else begin : g_unused
        assign wr_en[gi] = 1'b0;
      end
    end
  endgenerate

  // Owner storage, no reset needed since entries are only read when valid
  always_ff @(posedge clk) begin
    for (int i = 0; i < MAX_DEPTH; i++) begin
      if (wr_en[i]) mem_reg[i] <= push_id;
    end
  end

  // Pointer and occupancy next-state; push+pop leaves the count unchanged
  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    if (push) wr_ptr_next = ptr_inc(wr_ptr_reg, DEPTH);
    if (pop)  rd_ptr_next = ptr_inc(rd_ptr_reg, DEPTH);
    if (push && !pop)      count_next = count_reg + CNT_W'(1);
    else if (!push && pop) count_next = count_reg - CNT_W'(1);
  end

  // Pointer and occupancy registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
    end
  end

  assign head_id = mem_reg[rd_ptr_reg];
  assign count   = count_reg;
  assign empty   = (count_reg == '0);
  assign full    = (count_reg == CNT_W'(DEPTH));

endmodule

// File: rtl/sram_bus_arbiter.sv
// Shares one sram-like downstream port between the inst and data
// requesters. A requester that is not accepted immediately keeps the
// bus locked until addr_ok; responses are routed back in issue order
// using the owner FIFO.
module sram_bus_arbiter
  import sram_bus_arbiter_pkg::*;
#(
  parameter int OUTSTANDING = 2,
  parameter int DATA_PRIO   = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inst_sram_req,
  input  logic [1:0]       inst_sram_size,
  input  logic [31:0]      inst_sram_addr,
  output logic             inst_sram_addr_ok,
  output logic             inst_sram_data_ok,
  output logic [31:0]      inst_sram_rdata,
  input  logic             data_sram_req,
  input  logic             data_sram_wr,
  input  logic [1:0]       data_sram_size,
  input  logic [3:0]       data_sram_wstrb,
  input  logic [31:0]      data_sram_addr,
  input  logic [31:0]      data_sram_wdata,
  output logic             data_sram_addr_ok,
  output logic             data_sram_data_ok,
  output logic [31:0]      data_sram_rdata,
  output logic             bus_req,
  output logic             bus_wr,
  output logic [1:0]       bus_size,
  output logic [3:0]       bus_wstrb,
  output logic [31:0]      bus_addr,
  output logic [31:0]      bus_wdata,
  input  logic             bus_addr_ok,
  input  logic             bus_data_ok,
  input  logic [31:0]      bus_rdata,
  output logic [CNT_W-1:0] outstanding_cnt,
  output logic             proto_err
);

  lock_state_t      lock_reg, lock_next;
  logic             rr_reg, rr_next;
  logic             proto_err_reg;
  logic             grant_owner;
  logic             bus_req_c;
  logic             push, pop;
  logic             head_id;
  logic             fifo_empty, fifo_full;
  logic [CNT_W-1:0] fifo_count;

  // Arbitration and lock next-state; a full FIFO blocks any new issue
  always_comb begin
    grant_owner = SRC_INST;
    bus_req_c   = 1'b0;
    lock_next   = lock_reg;
    unique case (lock_reg)
      IDLE: begin
        if (!fifo_full && (inst_sram_req || data_sram_req)) begin
          bus_req_c = 1'b1;
          if (inst_sram_req && data_sram_req)
            grant_owner = (DATA_PRIO != 0) ? SRC_DATA : ~rr_reg;
          else
            grant_owner = data_sram_req ? SRC_DATA : SRC_INST;
          if (!bus_addr_ok)
            lock_next = (grant_owner == SRC_DATA) ? LOCK_DATA : LOCK_INST;
        end
      end
      LOCK_INST: begin
        grant_owner = SRC_INST;
        bus_req_c   = !fifo_full;
        if (bus_req_c && bus_addr_ok) lock_next = IDLE;
      end
      LOCK_DATA: begin
        grant_owner = SRC_DATA;
        bus_req_c   = !fifo_full;
        if (bus_req_c && bus_addr_ok) lock_next = IDLE;
      end
      default: lock_next = IDLE;
    endcase
    if (reset) bus_req_c = 1'b0;
  end

  assign push    = bus_req_c && bus_addr_ok;
  assign pop     = bus_data_ok && !fifo_empty && !reset;
  assign rr_next = push ? grant_owner : rr_reg;

  // Lock state and round-robin memory of the last accepted requester
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lock_reg <= IDLE;
      rr_reg   <= SRC_INST;
    end else begin
      lock_reg <= lock_next;
      rr_reg   <= rr_next;
    end
  end

  // Sticky flag for a response arriving with nothing outstanding
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                          proto_err_reg <= 1'b0;
    else if (bus_data_ok && fifo_empty) proto_err_reg <= 1'b1;
  end

  sram_bus_arbiter_owner_fifo #(
    .DEPTH(OUTSTANDING)
  ) u_owner_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (push),
    .push_id (grant_owner),
    .pop     (pop),
    .head_id (head_id),
    .count   (fifo_count),
    .empty   (fifo_empty),
    .full    (fifo_full)
  );

  // Downstream request mux; inst fetches are always plain reads
  assign bus_req   = bus_req_c;
  assign bus_wr    = (grant_owner == SRC_DATA) ? data_sram_wr    : 1'b0;
  assign bus_size  = (grant_owner == SRC_DATA) ? data_sram_size  : inst_sram_size;
  assign bus_wstrb = (grant_owner == SRC_DATA) ? data_sram_wstrb : 4'b0000;
  assign bus_addr  = (grant_owner == SRC_DATA) ? data_sram_addr  : inst_sram_addr;
  assign bus_wdata = (grant_owner == SRC_DATA) ? data_sram_wdata : 32'h0;

  assign inst_sram_addr_ok = push && (grant_owner == SRC_INST);
  assign data_sram_addr_ok = push && (grant_owner == SRC_DATA);

  // Response demux to the owner at the FIFO head
  assign inst_sram_data_ok = pop && (head_id == SRC_INST);
  assign data_sram_data_ok = pop && (head_id == SRC_DATA);
  assign inst_sram_rdata   = inst_sram_data_ok ? bus_rdata : 32'h0;
  assign data_sram_rdata   = data_sram_data_ok ? bus_rdata : 32'h0;

  assign outstanding_cnt = fifo_count;
  assign proto_err       = proto_err_reg;

  // A locked requester must keep its request up until accepted
  a_inst_hold: assert property (@(posedge clk) disable iff (reset)
                                (lock_reg == LOCK_INST) |-> inst_sram_req);
  a_data_hold: assert property (@(posedge clk) disable iff (reset)
                                (lock_reg == LOCK_DATA) |-> data_sram_req);

endmodule
